seg_display_capture: RTL

- Receive-side counterpart of the multiplexed 4-digit seven-segment driver.
- Samples the time-multiplexed seg/an lines, decodes each stable digit glyph back to a hex nibble, and reassembles the 16-bit value shown on the display.
- Used for on-board loopback and self-check of the display path: a display driver's seg/an outputs connect straight to this block's inputs.

---
 rtl/seg_display_capture.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seg_display_capture.sv
// seg_display_capture: samples a multiplexed 4-digit seven-segment bus (seg/an),
// decodes each stable digit glyph back to a hex nibble, and reassembles the
// 16-bit displayed value. Optional macro DP_CAPTURE_EN captures the decimal
// points into dp; without it dp is tied to zero.
module seg_display_capture #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        valid,
  output logic        frame_stb,
  output logic        err,
  output logic [3:0]  dp
);

  localparam int unsigned CW = 8;
  localparam int unsigned TW = 24;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      seg_s1, seg_s2, seg_p;
  logic [3:0]      an_s1, an_s2, an_p;
  logic            same_c, an_ok_c, capture_c;
  logic [TW-1:0]   tcnt;
  logic [3:0]      mask;
  logic [15:0]     slot_val;
  logic [3:0]      slot_bad;
  logic [4:0]      dec_c;

  // Glyph (active-high gfedcba) to {bad, nibble}
  function automatic logic [4:0] decode(input logic [6:0] g);
    case (g)
      7'h3F: decode = 5'h00;
      7'h06: decode = 5'h01;
      7'h5B: decode = 5'h02;
      7'h4F: decode = 5'h03;
      7'h66: decode = 5'h04;
      7'h6D: decode = 5'h05;
      7'h7D: decode = 5'h06;
      7'h07: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h6F: decode = 5'h09;
      7'h77: decode = 5'h0A;
      7'h7C: decode = 5'h0B;
      7'h39: decode = 5'h0C;
      7'h5E: decode = 5'h0D;
      7'h79: decode = 5'h0E;
      7'h71: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  // Two-flop input synchronisers plus one-cycle-old sample for stability compare
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_s1 <= 8'hFF;
      seg_s2 <= 8'hFF;
      seg_p  <= 8'hFF;
      an_s1  <= 4'hF;
      an_s2  <= 4'hF;
      an_p   <= 4'hF;
    end else begin
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
      an_s1  <= an;
      an_s2  <= an_s1;
      an_p   <= an_s2;
    end
  end

  assign same_c  = (seg_s2 == seg_p) && (an_s2 == an_p);
  assign an_ok_c = (an_s2 == 4'hE) || (an_s2 == 4'hD) ||
                   (an_s2 == 4'hB) || (an_s2 == 4'h7);
  // Capture decodes the last settled sample, not the live one
  assign dec_c   = decode(~seg_p[6:0]);

  // FSM state and settle counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: settle, capture once, then hold until the bus changes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (an_ok_c) begin
          cnt_d   = CW'(1);
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!an_ok_c || !same_c) begin
          state_d = S_IDLE;
        end else if ((9'(cnt_q) + 9'd1) >= 9'(SETTLE)) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CAPTURE: begin
        capture_c = 1'b1;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        if (!an_ok_c || !same_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DP_CAPTURE_EN
  logic [3:0] slot_dp;
`else
  assign dp = 4'b0000;
`endif

  // Slot storage, frame assembly, timeout and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt      <= '0;
      mask      <= '0;
      slot_val  <= '0;
      slot_bad  <= '0;
      value     <= '0;
      valid     <= 1'b0;
      frame_stb <= 1'b0;
      err       <= 1'b0;
`ifdef DP_CAPTURE_EN
      slot_dp   <= '0;
      dp        <= '0;
`endif
    end else begin
      frame_stb <= 1'b0;
      if (tcnt != TW'(TIMEOUT)) tcnt <= tcnt + TW'(1);
      if (mask == 4'hF) begin
        value     <= slot_val;
        err       <= |slot_bad;
        valid     <= 1'b1;
        frame_stb <= 1'b1;
        mask      <= '0;
`ifdef DP_CAPTURE_EN
        dp        <= slot_dp;
`endif
      end else if ((mask != 4'h0) && (tcnt == TW'(TIMEOUT))) begin
        mask     <= '0;
        slot_val <= '0;
        slot_bad <= '0;
`ifdef DP_CAPTURE_EN
        slot_dp  <= '0;
`endif
      end
      if (capture_c) begin
        tcnt <= '0;
        for (int i = 0; i < 4; i++) begin
          if (!an_p[i]) begin
            slot_val[4*i +: 4] <= dec_c[3:0];
            slot_bad[i]        <= dec_c[4];
            mask[i]            <= 1'b1;
`ifdef DP_CAPTURE_EN
            slot_dp[i]         <= ~seg_p[7];
`endif
          end
        end
      end
    end
  end

endmodule
